// File: rtl/regbank_mp.sv
// ----------------------------------------------------------------------------
// regbank_mp -- multi-port CPU register bank
//
// Holds NREGS general registers (index NREGS-1 is the PC) plus a CPSR.
// Three combinational read ports and two prioritised write ports (ALU
// writeback wins over load writeback). PC reads on ports A/B include a
// pipeline offset. Optional same-cycle write-to-read bypass. A per-register
// busy scoreboard flags load-use hazards.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ra_addr/ra_en/ra_data      read port A (Rn), PC-offset applied
//   rb_addr/rb_en/rb_data      read port B (Rm), PC-offset applied
//   rs_addr/rs_en/rs_data      shift-amount port, low byte, no PC offset
//   wa_en/wa_addr/wa_data      ALU writeback (higher priority)
//   wl_en/wl_addr/wl_data      load writeback, also clears busy
//   lock_en/lock_addr          mark a register busy (load issued)
//   pc_load/pc_target          branch
//   pc_hold                    freeze PC
//   pc_out                     registered PC
//   flags_we/flags_in          update CPSR[31:28] (NZCV)
//   cpsr_out                   registered CPSR
//   hazard                     an enabled read port hits a busy register
// ----------------------------------------------------------------------------
module regbank_mp #(
  parameter int                DATA_W    = 32,
  parameter int                NREGS     = 16,
  parameter int                ADDR_W    = 4,
  parameter int                PC_INC    = 4,
  parameter int                PC_RD_OFS = 8,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] CPSR_RST  = 'h1D3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic              ra_en,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              rb_en,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rs_en,
  output logic [7:0]        rs_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wl_en,
  input  logic [ADDR_W-1:0] wl_addr,
  input  logic [DATA_W-1:0] wl_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_target,
  input  logic              pc_hold,
  output logic [DATA_W-1:0] pc_out,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] cpsr_out,
  output logic              hazard
);

  localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W + 1)'(NREGS);
  localparam logic [DATA_W-1:0] PC_OFS  = DATA_W'(PC_RD_OFS);
  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);
  localparam bit                BYP_ON  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [DATA_W-1:0] cpsr;
  logic [DATA_W-1:0] pc_next;

  assign pc_out   = regs[PC_IDX];
  assign cpsr_out = cpsr;

  // Addresses beyond the implemented register count read as zero, are
  // never written and never report busy.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_A);
  endfunction

  // Full-width read without PC offset. Forwarding never applies to the PC:
  // its next value also depends on branch/hold, so a read of PC always
  // sees the registered value.
  function automatic logic [DATA_W-1:0] rd_raw(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_range(a)) begin
      v = regs[a];
      if (BYP_ON && (a != PC_IDX)) begin
        if (wa_en && (wa_addr == a))      v = wa_data;
        else if (wl_en && (wl_addr == a)) v = wl_data;
      end
    end
    return v;
  endfunction

  // Low byte read for the shift-amount port; same selection as rd_raw.
  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = '0;
    if (in_range(a)) begin
      v = regs[a][7:0];
      if (BYP_ON && (a != PC_IDX)) begin
        if (wa_en && (wa_addr == a))      v = wa_data[7:0];
        else if (wl_en && (wl_addr == a)) v = wl_data[7:0];
      end
    end
    return v;
  endfunction

  // A register is effectively busy unless its load data is being forwarded
  // this very cycle.
  function automatic logic busy_eff(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    if (in_range(a)) begin
      b = busy[a];
      if (BYP_ON && (a != PC_IDX) && wl_en && (wl_addr == a)) b = 1'b0;
    end
    return b;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional assignment; otherwise a path leaves it unassigned and a
  // latch is inferred.
  always_comb begin
    ra_data = rd_raw(ra_addr);
    rb_data = rd_raw(rb_addr);
    if (ra_addr == PC_IDX) ra_data = ra_data + PC_OFS;
    if (rb_addr == PC_IDX) rb_data = rb_data + PC_OFS;
    rs_data = rd_byte(rs_addr);
    hazard  = (ra_en && busy_eff(ra_addr)) ||
              (rb_en && busy_eff(rb_addr)) ||
              (rs_en && busy_eff(rs_addr));
  end

  // PC next value: writebacks beat branches, branches beat stalls.
  always_comb begin
    pc_next = regs[PC_IDX] + PC_STEP;
    if (wa_en && (wa_addr == PC_IDX))      pc_next = wa_data;
    else if (wl_en && (wl_addr == PC_IDX)) pc_next = wl_data;
    else if (pc_load)                      pc_next = pc_target;
    else if (pc_hold)                      pc_next = regs[PC_IDX];
  end

  // NOTE: the register file is reset as a whole because zeroed registers
  // are architectural state; this keeps it in flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        // ALU result is from the younger instruction, so it wins a collision.
        if (wa_en && (wa_addr == ADDR_W'(i)))      regs[i] <= wa_data;
        else if (wl_en && (wl_addr == ADDR_W'(i))) regs[i] <= wl_data;
      end
      regs[PC_IDX] <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr <= CPSR_RST;
    end else if (flags_we) begin
      cpsr[DATA_W-1:DATA_W-4] <= flags_in;
    end
  end

  // Scoreboard: a new load to the same register must stay busy even when an
  // older load to it retires in the same cycle, so set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (lock_en && (lock_addr == ADDR_W'(i)))  busy[i] <= 1'b1;
        else if (wl_en && (wl_addr == ADDR_W'(i))) busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
Parametrised multi-port register bank, the successor to the single-writeback register bank in the CPU datapath. It holds NREGS general registers, with the top index acting as PC, plus a CPSR. It provides three combinational read ports (A, B, shift-amount) and two prioritised write ports: ALU writeback and load writeback. It adds PC-relative read offset, optional write-to-read bypass, and a per-register busy scoreboard that flags load-use hazards to the control unit.

Parameters:
DATA_W, 32, register width in bits
NREGS, 16, number of architectural registers; index NREGS-1 is PC
ADDR_W, 4, register address width; must satisfy 2^ADDR_W >= NREGS
PC_INC, 4, sequential PC increment per cycle
PC_RD_OFS, 8, offset added to PC when PC is read through port A or B
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see the registered value
CPSR_RST, 32'h000001D3, CPSR reset value: FIQ/IRQ disabled, T clear, supervisor mode

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
ra_addr  in  ADDR_W  port A (Rn) address
ra_en  in  1  port A operand is used this cycle (hazard qualification)
ra_data  out  DATA_W  port A data
rb_addr  in  ADDR_W  port B (Rm) address
rb_en  in  1  port B operand is used this cycle
rb_data  out  DATA_W  port B data
rs_addr  in  ADDR_W  shift-amount (Rs) address
rs_en  in  1  Rs operand is used this cycle
rs_data  out  8  low byte of Rs
wa_en  in  1  ALU writeback enable
wa_addr  in  ADDR_W  ALU writeback address
wa_data  in  DATA_W  ALU writeback data
wl_en  in  1  load writeback enable; also clears the busy bit
wl_addr  in  ADDR_W  load writeback address
wl_data  in  DATA_W  load writeback data
lock_en  in  1  mark a register busy (load issued)
lock_addr  in  ADDR_W  register to mark busy
pc_load  in  1  branch: PC <= pc_target
pc_target  in  DATA_W  branch target
pc_hold  in  1  freeze PC (stall)
pc_out  out  DATA_W  registered PC, used for instruction fetch
flags_we  in  1  update CPSR[31:28]
flags_in  in  4  new NZCV flags
cpsr_out  out  DATA_W  registered CPSR
hazard  out  1  an enabled read port addresses a busy register

Behaviour:
- Reset, asynchronous on rst_n low:
  - all registers including PC = 0
  - CPSR = CPSR_RST
  - busy = 0, so hazard = 0
  - pc_out = 0, cpsr_out = CPSR_RST
- Read ports are combinational.
  - Address NREGS-1 on port A or B returns PC + PC_RD_OFS, truncated to DATA_W.
  - rs_data = bits [7:0] of the addressed register; no PC offset is applied on this port.
  - Address >= NREGS returns 0.
- Bypass, when BYPASS=1, for a non-PC read address:
  - wa_en and wa_addr match: return wa_data.
  - Otherwise, wl_en and wl_addr match: return wl_data.
  - Applies to rs_data as well.
  - BYPASS=0: reads return the registered value only; the write is visible from the next cycle.
- GPR write, same edge, both ports enabled:
  - Different addresses: both writes happen.
  - Same address: wa wins, because the ALU result is from the younger instruction.
  - Writes to address >= NREGS are ignored.
- PC next-value priority, highest first:
  1. wa write to PC
  2. wl write to PC
  3. pc_load: pc_target
  4. pc_hold: unchanged
  5. otherwise: PC + PC_INC, wrapping modulo 2^DATA_W
- CPSR:
  - flags_we: CPSR[31:28] <= flags_in; bits [27:0] unchanged.
  - The CPSR is not addressable through the write ports.
- Scoreboard: one busy bit per register.
  - lock_en sets busy[lock_addr].
  - wl_en clears busy[wl_addr].
  - Same address, same cycle: set wins.
  - wa writes do not touch busy bits.
- hazard is combinational: (ra_en & busy[ra_addr]) | (rb_en & busy[rb_addr]) | (rs_en & busy[rs_addr]).
  - A load writeback in the same cycle as the read suppresses that register's contribution to hazard when BYPASS=1, since the data is forwarded.
- Reset mid-operation overrides all pending writes, locks and branches immediately.

Test Plan:
- Reset: rst_n low with random inputs -> pc_out=0, cpsr_out=0x000001D3, ra_data=0 for r3, hazard=0; rst_n high with no controls -> pc_out 0,4,8 on successive edges.
- Dual write: wa r1=0x11, wl r2=0x22 in one cycle -> next cycle r1=0x11, r2=0x22; then wa and wl both target r5 (0xAA / 0xBB) -> r5=0xAA.
- Bypass: BYPASS=1, wa r7=0xDEAD with ra_addr=7 -> ra_data=0xDEAD the same cycle; BYPASS=0 -> old value, then 0xDEAD after the edge.
- PC priority: pc=0x100, pc_load target 0x200 and pc_hold together -> 0x200; wa to r15=0x300 with pc_load -> 0x300; ra_addr=15 at pc=0x300 -> 0x308.
- Scoreboard: lock r4; next cycle ra_en, ra_addr=4 -> hazard=1; wl r4=0x55 -> hazard=0 (BYPASS=1) and ra_data=0x55; lock and wl on r4 in the same cycle -> busy stays 1.
- Flags: flags_we, flags_in=4'b1010 -> cpsr_out=0xA00001D3; rs r6=0x1234 -> rs_data=0x34.
